// File: rtl/pe_layer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_layer_scheduler: serial top/second visible-layer picker for one pixel |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pe_layer_scheduler #(
  parameter int NUM_LAYERS = 5,
  parameter int PRIO_W     = 2,
  parameter int COLOR_W    = 15,
  parameter int IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*PRIO_W-1:0]  layer_prio,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [COLOR_W-1:0]            backdrop_color,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              top_layer,
  output logic [COLOR_W-1:0]            top_color,
  output logic [IDX_W-1:0]              second_layer,
  output logic [COLOR_W-1:0]            second_color
);

  localparam int CNT_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0]  C_BACKDROP   = IDX_W'(NUM_LAYERS);
  localparam logic [IDX_W-1:0]  C_OBJ_IDX    = IDX_W'(NUM_LAYERS - 1);
  localparam logic [PRIO_W:0]   C_PRIO_WORST = {1'b1, {PRIO_W{1'b0}}};
  localparam logic [CNT_W-1:0]  C_LAST_STEP  = CNT_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_step;
  logic [NUM_LAYERS-1:0]         r_valid;
  logic [NUM_LAYERS*PRIO_W-1:0]  r_prio;
  logic [NUM_LAYERS*COLOR_W-1:0] r_color;

  logic [IDX_W-1:0]   r_best_idx,   r_sec_idx;
  logic [PRIO_W:0]    r_best_prio,  r_sec_prio;
  logic [COLOR_W-1:0] r_best_color, r_sec_color;

  logic               r_busy, r_done;
  logic [IDX_W-1:0]   r_top_layer, r_second_layer;
  logic [COLOR_W-1:0] r_top_color, r_second_color;

  logic [PRIO_W-1:0]  w_prio_arr  [NUM_LAYERS];
  logic [COLOR_W-1:0] w_color_arr [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
    assign w_prio_arr[gi]  = r_prio[gi*PRIO_W +: PRIO_W];
    assign w_color_arr[gi] = r_color[gi*COLOR_W +: COLOR_W];
  end

  // Step 0 visits OBJ so that it wins equal-priority ties against every BG.
  logic [IDX_W-1:0]   w_cand_idx;
  logic               w_cand_valid;
  logic [PRIO_W:0]    w_cand_prio;
  logic [COLOR_W-1:0] w_cand_color;

  assign w_cand_idx   = (r_step == '0) ? C_OBJ_IDX : (IDX_W'(r_step) - IDX_W'(1));
  assign w_cand_valid = r_valid[w_cand_idx];
  assign w_cand_prio  = {1'b0, w_prio_arr[w_cand_idx]};
  assign w_cand_color = w_color_arr[w_cand_idx];

  logic [IDX_W-1:0]   w_best_idx_nxt,   w_sec_idx_nxt;
  logic [PRIO_W:0]    w_best_prio_nxt,  w_sec_prio_nxt;
  logic [COLOR_W-1:0] w_best_color_nxt, w_sec_color_nxt;

  always_comb begin
    w_best_idx_nxt   = r_best_idx;
    w_best_prio_nxt  = r_best_prio;
    w_best_color_nxt = r_best_color;
    w_sec_idx_nxt    = r_sec_idx;
    w_sec_prio_nxt   = r_sec_prio;
    w_sec_color_nxt  = r_sec_color;
    if (w_cand_valid) begin
      if (w_cand_prio < r_best_prio) begin
        w_sec_idx_nxt    = r_best_idx;
        w_sec_prio_nxt   = r_best_prio;
        w_sec_color_nxt  = r_best_color;
        w_best_idx_nxt   = w_cand_idx;
        w_best_prio_nxt  = w_cand_prio;
        w_best_color_nxt = w_cand_color;
      end else if (w_cand_prio < r_sec_prio) begin
        w_sec_idx_nxt    = w_cand_idx;
        w_sec_prio_nxt   = w_cand_prio;
        w_sec_color_nxt  = w_cand_color;
      end
    end
  end

  logic w_load;
  assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_step         <= '0;
      r_valid        <= '0;
      r_prio         <= '0;
      r_color        <= '0;
      r_best_idx     <= C_BACKDROP;
      r_best_prio    <= C_PRIO_WORST;
      r_best_color   <= '0;
      r_sec_idx      <= C_BACKDROP;
      r_sec_prio     <= C_PRIO_WORST;
      r_sec_color    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_top_layer    <= C_BACKDROP;
      r_top_color    <= '0;
      r_second_layer <= C_BACKDROP;
      r_second_color <= '0;
    end else begin
      r_done <= 1'b0;
      // Snapshot makes the result independent of input changes after start.
      if (w_load) begin
        r_valid      <= layer_valid;
        r_prio       <= layer_prio;
        r_color      <= layer_color;
        r_best_idx   <= C_BACKDROP;
        r_best_prio  <= C_PRIO_WORST;
        r_best_color <= backdrop_color;
        r_sec_idx    <= C_BACKDROP;
        r_sec_prio   <= C_PRIO_WORST;
        r_sec_color  <= backdrop_color;
        r_step       <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          r_best_idx   <= w_best_idx_nxt;
          r_best_prio  <= w_best_prio_nxt;
          r_best_color <= w_best_color_nxt;
          r_sec_idx    <= w_sec_idx_nxt;
          r_sec_prio   <= w_sec_prio_nxt;
          r_sec_color  <= w_sec_color_nxt;
          r_step       <= r_step + CNT_W'(1);
          // Publish from the next-state values so the final candidate counts.
          if (r_step == C_LAST_STEP) begin
            r_state        <= ST_DONE;
            r_done         <= 1'b1;
            r_top_layer    <= w_best_idx_nxt;
            r_top_color    <= w_best_color_nxt;
            r_second_layer <= w_sec_idx_nxt;
            r_second_color <= w_sec_color_nxt;
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign top_layer    = r_top_layer;
  assign top_color    = r_top_color;
  assign second_layer = r_second_layer;
  assign second_color = r_second_color;

endmodule
`default_nettype wire

// File: tb/tb_pe_layer_scheduler.sv
`default_nettype none
// Scoreboard bench for pe_layer_scheduler: directed pixels, expected results
// queued at issue and popped by a monitor on every done pulse.
module tb_pe_layer_scheduler;

  localparam int NL = 5;
  localparam int PW = 2;
  localparam int CW = 15;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NL-1:0]     layer_valid;
  logic [NL*PW-1:0]  layer_prio;
  logic [NL*CW-1:0]  layer_color;
  logic [CW-1:0]     backdrop_color;
  logic              busy, done;
  logic [IW-1:0]     top_layer, second_layer;
  logic [CW-1:0]     top_color, second_color;

  always #5 clk = ~clk;

  pe_layer_scheduler #(
    .NUM_LAYERS(NL), .PRIO_W(PW), .COLOR_W(CW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .layer_valid(layer_valid), .layer_prio(layer_prio),
    .layer_color(layer_color), .backdrop_color(backdrop_color),
    .busy(busy), .done(done),
    .top_layer(top_layer), .top_color(top_color),
    .second_layer(second_layer), .second_color(second_color)
  );

  typedef struct packed {
    logic [IW-1:0] tl;
    logic [CW-1:0] tc;
    logic [IW-1:0] sl;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [IW-1:0] tl, input logic [CW-1:0] tc,
                              input logic [IW-1:0] sl, input logic [CW-1:0] sc);
    exp_t e;
    e.tl = tl; e.tc = tc; e.sl = sl; e.sc = sc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk("top_layer",    32'(top_layer),    32'(e.tl));
          chk("top_color",    32'(top_color),    32'(e.tc));
          chk("second_layer", 32'(second_layer), 32'(e.sl));
          chk("second_color", 32'(second_color), 32'(e.sc));
        end
      end
    end
  end

  task automatic set_px(input logic [NL-1:0] v, input logic [NL*PW-1:0] p,
                        input logic [NL*CW-1:0] c, input logic [CW-1:0] bd);
    layer_valid    = v;
    layer_prio     = p;
    layer_color    = c;
    backdrop_color = bd;
  endtask

  task automatic scramble();
    layer_valid    = '1;
    layer_prio     = '0;
    layer_color    = '1;
    backdrop_color = '1;
  endtask

  task automatic run_pixel(input logic [NL-1:0] v, input logic [NL*PW-1:0] p,
                           input logic [NL*CW-1:0] c, input logic [CW-1:0] bd,
                           input exp_t e, input bit mid_start);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    set_px(v, p, c, bd);
    start = 1'b1;
    sb.push_back(e);
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        scramble();
        chk("busy_scan", 32'(busy), 32'd1);
      end
      if (mid_start) start = (k == 3);
      if (done === 1'b1) seen = 1;
    end
    chk("latency", 32'(k), 32'd6);
    chk("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
  endtask

  // Directed pixel vectors; packing is {OBJ, BG3, BG2, BG1, BG0}.
  localparam logic [NL-1:0]    V1_V = 5'b00101;
  localparam logic [NL*PW-1:0] V1_P = {2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
  localparam logic [NL*CW-1:0] V1_C = {15'h0000, 15'h0000, 15'h03E0, 15'h0000, 15'h001F};

  localparam logic [NL-1:0]    V2_V = 5'b11111;
  localparam logic [NL*PW-1:0] V2_P = '0;
  localparam logic [NL*CW-1:0] V2_C = {15'h7C00, 15'h0004, 15'h0003, 15'h0002, 15'h0001};

  localparam logic [NL*CW-1:0] V3_C = {15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF};

  localparam logic [NL-1:0]    V4_V = 5'b01000;
  localparam logic [NL*PW-1:0] V4_P = {2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
  localparam logic [NL*CW-1:0] V4_C = {15'h1111, 15'h0ABC, 15'h1111, 15'h1111, 15'h1111};

  localparam logic [NL-1:0]    V5_V = 5'b10110;
  localparam logic [NL*PW-1:0] V5_P = {2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  localparam logic [NL*CW-1:0] V5_C = {15'h1111, 15'h0000, 15'h3333, 15'h2222, 15'h0000};

  localparam logic [NL-1:0]    V6_V = 5'b10001;
  localparam logic [NL*PW-1:0] V6_P = {2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [NL*CW-1:0] V6_C = {15'h7FFF, 15'h0000, 15'h0000, 15'h0000, 15'h4321};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dk[$];
    rst   = 1'b1;
    start = 1'b0;
    set_px('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_done",   32'(done),         32'd0);
    chk("rst_top",    32'(top_layer),    32'd5);
    chk("rst_second", 32'(second_layer), 32'd5);
    chk("rst_tcolor", 32'(top_color),    32'd0);
    chk("rst_scolor", 32'(second_color), 32'd0);

    run_pixel(V1_V, V1_P, V1_C, 15'h0000, mk(3'd2, 15'h03E0, 3'd0, 15'h001F), 0);
    run_pixel(V2_V, V2_P, V2_C, 15'h0000, mk(3'd4, 15'h7C00, 3'd0, 15'h0001), 1);
    repeat (8) @(negedge clk);
    run_pixel('0, '0, V3_C, 15'h1234, mk(3'd5, 15'h1234, 3'd5, 15'h1234), 0);
    chk("hold_top", 32'(top_layer), 32'd5);
    run_pixel(V4_V, V4_P, V4_C, 15'h0055, mk(3'd3, 15'h0ABC, 3'd5, 15'h0055), 0);
    run_pixel(V5_V, V5_P, V5_C, 15'h0000, mk(3'd1, 15'h2222, 3'd2, 15'h3333), 0);

    // Back-to-back: start held for 14 edges yields three pixels, 6 cycles apart.
    sb.push_back(mk(3'd1, 15'h2222, 3'd2, 15'h3333));
    sb.push_back(mk(3'd0, 15'h4321, 3'd4, 15'h7FFF));
    sb.push_back(mk(3'd2, 15'h03E0, 3'd0, 15'h001F));
    set_px(V5_V, V5_P, V5_C, 15'h0000);
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1)  set_px(V6_V, V6_P, V6_C, 15'h0000);
      if (k == 7)  set_px(V1_V, V1_P, V1_C, 15'h0000);
      if (k == 14) start = 1'b0;
      if (done === 1'b1) dk.push_back(k);
    end
    chk("b2b_count", 32'(dk.size()), 32'd3);
    if (dk.size() > 0) chk("b2b_done0", 32'(dk[0]), 32'd6);
    if (dk.size() > 1) chk("b2b_done1", 32'(dk[1]), 32'd12);
    if (dk.size() > 2) chk("b2b_done2", 32'(dk[2]), 32'd18);

    // Reset at scan step 2, with a start coinciding with the reset.
    set_px(V2_V, V2_P, V2_C, 15'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("mid_rst_busy",   32'(busy),         32'd0);
    chk("mid_rst_done",   32'(done),         32'd0);
    chk("mid_rst_top",    32'(top_layer),    32'd5);
    chk("mid_rst_second", 32'(second_layer), 32'd5);
    chk("mid_rst_tcolor", 32'(top_color),    32'd0);
    chk("mid_rst_scolor", 32'(second_color), 32'd0);
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_pixel(V6_V, V6_P, V6_C, 15'h0000, mk(3'd0, 15'h4321, 3'd4, 15'h7FFF), 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_layer_scheduler.md
Name: pe_layer_scheduler

Overview:
- Sequential per-pixel priority evaluator for the compositor. Serially scans the BG0–BG3 and OBJ layer candidates and selects the top-most visible layer and the second-most layer, which the alpha-blend stage uses.
- Uses one shared magnitude comparison per cycle instead of a full parallel tree.
- Sits between the layer fetch units and the colour-effects stage.
- Start/busy/done handshake with the pixel pipeline.

Parameters:
- NUM_LAYERS, 5: candidate layers. Index 0..NUM_LAYERS-2 are BGs; index NUM_LAYERS-1 is OBJ.
- PRIO_W, 2: priority field width. A lower value is higher priority.
- COLOR_W, 15: BGR555 colour width.
- IDX_W, 3: layer index width. Value NUM_LAYERS encodes backdrop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request evaluation of one pixel; inputs sampled this cycle
- layer_valid  in  NUM_LAYERS  per-layer opaque/enabled (window already applied)
- layer_prio  in  NUM_LAYERS*PRIO_W  packed priorities; layer i at [i*PRIO_W +: PRIO_W]
- layer_color  in  NUM_LAYERS*COLOR_W  packed colours, same packing
- backdrop_color  in  COLOR_W  palette entry 0
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results valid
- top_layer  out  IDX_W  winning layer index
- top_color  out  COLOR_W  winning colour
- second_layer  out  IDX_W  runner-up index
- second_color  out  COLOR_W  runner-up colour

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - busy=0, done=0.
  - top_layer=second_layer=NUM_LAYERS (backdrop).
  - top_color=second_color=0.
  - FSM=IDLE, counter=0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 → snapshot all inputs into internal registers. Init best={backdrop, prio=2^PRIO_W} and second={backdrop, prio=2^PRIO_W}; this uses a PRIO_W+1 bit field, so backdrop is worse than any layer. Clear step counter; go to SCAN.
  - SCAN: one candidate per cycle, for exactly NUM_LAYERS cycles. Scan order: OBJ (NUM_LAYERS-1) at step 0, then BG0, BG1, …, BG(NUM_LAYERS-2). After the last step go to DONE.
  - DONE: publish best/second to outputs (outputs registered; update on the DONE-entry edge), done=1 for this cycle. Next state is SCAN if start=1 (back-to-back, new snapshot taken), else IDLE.
- busy=1 in SCAN and DONE states.
- start is ignored in SCAN and has no side effects.
- Per-step update, candidate c with valid v and priority p:
  - v=0: no change.
  - p < best.prio (strict): second<=best; best<=c.
  - else if p < second.prio (strict): second<=c.
  - else: no change.
- Tie rules, resulting from strict compare plus scan order:
  - OBJ beats BG at equal priority.
  - A lower BG index beats a higher one at equal priority.
  - An equal-priority later candidate can still become second.
- No valid layers: top=backdrop with backdrop_color; second=backdrop with backdrop_color.
- Exactly one valid layer: second=backdrop.
- Latency: start sampled at edge T → done=1 in cycle T+NUM_LAYERS+1. Throughput is one pixel per NUM_LAYERS+1 cycles with start held or repulsed in DONE.
- Outputs hold their last published values between done pulses. Input changes after the start cycle do not affect the result.
- rst asserted mid-scan: next cycle is the full reset state, with no done pulse. A start in the same cycle as rst is ignored.

Test Plan:
- Reset then idle 10 cycles → busy=0, done=0, top_layer=5, second_layer=5, colours 0.
- start with valid=5'b00101, prio BG0=2, BG2=1, colours BG0=0x001F, BG2=0x03E0 → done at T+6: top=2/0x03E0, second=0/0x001F.
- Tie: valid=all, all prio=0, OBJ colour=0x7C00, BG0=0x0001 → top=4/0x7C00, second=0/0x0001.
- valid=0, backdrop_color=0x1234 → top=5/0x1234, second=5/0x1234.
- Back-to-back: start held high for 14 cycles → done pulses exactly every 6 cycles. A start pulse mid-SCAN does not restart the scan.
- Reset at scan step 2 → no done pulse; outputs return to reset values next cycle. A new start completes normally in 6 cycles.
